// File: rtl/mem_stage_if.sv
// Data-memory request/hit bus between mem_stage and the data cache.
// master issues requests; slave answers with dhit/dload.
interface mem_stage_if #(
  parameter int WORD_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dload
  );
endinterface

// File: rtl/mem_stage.sv
// EX/MEM register, data-memory access control and MEM/WB register.
// Stalls upstream while a memory request is outstanding.
module mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic [WORD_W-1:0] aluout,
  input  logic [WORD_W-1:0] dmemstore_in,
  input  logic [WORD_W-1:0] npc,
  input  logic [WORD_W-1:0] luiv,
  input  logic              dren,
  input  logic              dwen,
  input  logic              regwr,
  input  logic [1:0]        regsel,
  input  logic [REG_W-1:0]  regdst,
  input  logic              halt,
  mem_stage_if.master       dmem,
  output logic              mem_stall,
  output logic              fwd_regwr,
  output logic [REG_W-1:0]  fwd_regdst,
  output logic [WORD_W-1:0] fwd_val,
  output logic              wb_regwr,
  output logic [REG_W-1:0]  wb_regdst,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              wb_halt
);

  typedef struct packed {
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] store;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] luiv;
    logic              dren;
    logic              dwen;
    logic              regwr;
    logic [1:0]        regsel;
    logic [REG_W-1:0]  regdst;
    logic              halt;
  } ex_mem_t;

  typedef enum logic {IDLE, ACCESS} state_t;

  ex_mem_t           xm;
  ex_mem_t           xm_in;
  state_t            state;
  state_t            state_nxt;
  logic              done;
  logic [WORD_W-1:0] ld_data;
  logic              rd_req;
  logic              wr_req;
  logic              req;
  logic              capture;
  logic              is_load;
  logic [WORD_W-1:0] ld_val;
  logic [WORD_W-1:0] wdat;

  assign xm_in = '{
    alu:    aluout,
    store:  dmemstore_in,
    npc:    npc,
    luiv:   luiv,
    dren:   dren,
    dwen:   dwen,
    regwr:  regwr,
    regsel: regsel,
    regdst: regdst,
    halt:   halt
  };

  // a write wins over a simultaneous read
  assign rd_req    = xm.dren & ~xm.dwen & ~done;
  assign wr_req    = xm.dwen & ~done;
  assign req       = rd_req | wr_req;
  assign mem_stall = req & ~dmem.dhit;
  assign capture   = ~mem_stall & (flush | en);

  assign dmem.dmemREN   = rd_req;
  assign dmem.dmemWEN   = wr_req;
  assign dmem.dmemaddr  = xm.alu;
  assign dmem.dmemstore = xm.store;

  // EX/MEM capture; done/ld_data keep a held load from re-requesting
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      xm      <= '0;
      done    <= 1'b0;
      ld_data <= '0;
    end else if (capture) begin
      xm   <= flush ? '0 : xm_in;
      done <= 1'b0;
    end else if (dmem.dhit & req) begin
      done    <= 1'b1;
      ld_data <= dmem.dload;
    end
  end

  // access FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // access FSM next state; zero-wait hits never leave IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (mem_stall) state_nxt = ACCESS;
      ACCESS: if (dmem.dhit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // forwarding value: everything except load data
  always_comb begin
    fwd_val = xm.alu;
    unique case (xm.regsel)
      2'd2:    fwd_val = xm.npc;
      2'd3:    fwd_val = xm.luiv;
      default: fwd_val = xm.alu;
    endcase
  end

  assign fwd_regwr  = xm.regwr;
  assign fwd_regdst = xm.regdst;

  assign is_load = (xm.regsel == 2'd1) & xm.dren & ~xm.dwen;
  assign ld_val  = done ? ld_data : dmem.dload;
  assign wdat    = is_load ? ld_val : fwd_val;

  // MEM/WB: bubble while stalled so nothing is written twice
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_regwr  <= 1'b0;
      wb_regdst <= '0;
      wb_wdat   <= '0;
      wb_halt   <= 1'b0;
    end else if (mem_stall) begin
      wb_regwr  <= 1'b0;
      wb_regdst <= '0;
      wb_wdat   <= '0;
    end else begin
      wb_regwr  <= xm.regwr;
      wb_regdst <= xm.regdst;
      wb_wdat   <= wdat;
      wb_halt   <= wb_halt | xm.halt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random traffic
// against an instruction-slot reference model.
module tb_mem_stage;
  localparam int W = 32;
  localparam int R = 5;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] st;
    logic [31:0] npc;
    logic [31:0] lui;
    logic        dren;
    logic        dwen;
    logic        regwr;
    logic [1:0]  regsel;
    logic [4:0]  regdst;
    logic        halt;
  } ins_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  aluout = '0;
  logic [W-1:0]  dmemstore_in = '0;
  logic [W-1:0]  npc = '0;
  logic [W-1:0]  luiv = '0;
  logic          dren = 1'b0;
  logic          dwen = 1'b0;
  logic          regwr = 1'b0;
  logic [1:0]    regsel = '0;
  logic [R-1:0]  regdst = '0;
  logic          halt = 1'b0;
  logic          mem_stall;
  logic          fwd_regwr;
  logic [R-1:0]  fwd_regdst;
  logic [W-1:0]  fwd_val;
  logic          wb_regwr;
  logic [R-1:0]  wb_regdst;
  logic [W-1:0]  wb_wdat;
  logic          wb_halt;

  mem_stage_if #(.WORD_W(W)) dmem ();

  mem_stage #(.WORD_W(W), .REG_W(R)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .aluout(aluout), .dmemstore_in(dmemstore_in),
    .npc(npc), .luiv(luiv), .dren(dren), .dwen(dwen),
    .regwr(regwr), .regsel(regsel), .regdst(regdst),
    .halt(halt), .dmem(dmem),
    .mem_stall(mem_stall), .fwd_regwr(fwd_regwr),
    .fwd_regdst(fwd_regdst), .fwd_val(fwd_val),
    .wb_regwr(wb_regwr), .wb_regdst(wb_regdst),
    .wb_wdat(wb_wdat), .wb_halt(wb_halt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  ins_t        m_slot;
  bit          m_done;
  logic [31:0] m_ld;
  bit          m_halt;
  int          wait_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sel_val(input ins_t i);
    case (i.regsel)
      2'd2:    return i.npc;
      2'd3:    return i.lui;
      default: return i.alu;
    endcase
  endfunction

  function automatic bit is_rd(input ins_t i);
    return i.dren && !i.dwen;
  endfunction

  function automatic ins_t mk(input logic [31:0] a, input logic [31:0] s,
                              input bit r, input bit w, input bit rw,
                              input logic [1:0] sel, input logic [4:0] d,
                              input bit h);
    ins_t i;
    i.alu = a; i.st = s; i.npc = 32'h404; i.lui = 32'hABCD0000;
    i.dren = r; i.dwen = w; i.regwr = rw;
    i.regsel = sel; i.regdst = d; i.halt = h;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int k;
    k = $urandom_range(0, 9);
    i.alu = $urandom; i.st = $urandom;
    i.npc = $urandom; i.lui = $urandom;
    i.dren = (k <= 2) || (k == 5);
    i.dwen = (k == 3) || (k == 4) || (k == 5);
    i.regwr = $urandom_range(0, 1);
    i.regsel = (k <= 1) ? 2'd1 : 2'($urandom_range(0, 3));
    i.regdst = 5'($urandom);
    i.halt = ($urandom_range(0, 63) == 0);
    return i;
  endfunction

  task automatic drive(input ins_t i);
    aluout = i.alu; dmemstore_in = i.st; npc = i.npc; luiv = i.lui;
    dren = i.dren; dwen = i.dwen; regwr = i.regwr;
    regsel = i.regsel; regdst = i.regdst; halt = i.halt;
  endtask

  // one clock: nx offered with en/flush; w = wait cycles if nx is captured
  task automatic cyc(input ins_t nx, input bit e, input bit f,
                     input int w);
    bit rd, wr, hit, stall;
    logic [31:0] exp_wd;
    @(negedge CLK);
    rd = is_rd(m_slot) && !m_done;
    wr = m_slot.dwen && !m_done;
    hit = 1'b0;
    if (rd || wr) begin
      if (wait_cnt == 0) hit = 1'b1;
      else wait_cnt--;
    end
    dmem.dhit = hit;
    dmem.dload = $urandom;
    drive(nx);
    en = e;
    flush = f;
    #1;
    check("dmemREN", dmem.dmemREN, 32'(rd));
    check("dmemWEN", dmem.dmemWEN, 32'(wr));
    if (rd || wr) begin
      check("dmemaddr", dmem.dmemaddr, m_slot.alu);
      check("dmemstore", dmem.dmemstore, m_slot.st);
    end
    stall = (rd || wr) && !hit;
    check("mem_stall", mem_stall, 32'(stall));
    check("fwd_regwr", fwd_regwr, 32'(m_slot.regwr));
    check("fwd_regdst", fwd_regdst, 32'(m_slot.regdst));
    check("fwd_val", fwd_val, sel_val(m_slot));
    if (hit && rd) m_ld = dmem.dload;
    exp_wd = (m_slot.regsel == 2'd1 && is_rd(m_slot)) ? m_ld
                                                      : sel_val(m_slot);
    @(posedge CLK);
    #1;
    if (stall) begin
      check("wb_regwr_bubble", wb_regwr, 0);
    end else begin
      m_halt = m_halt || m_slot.halt;
      check("wb_regwr", wb_regwr, 32'(m_slot.regwr));
      check("wb_regdst", wb_regdst, 32'(m_slot.regdst));
      check("wb_wdat", wb_wdat, exp_wd);
    end
    check("wb_halt", wb_halt, 32'(m_halt));
    if (!stall && (f || e)) begin
      m_slot = f ? '0 : nx;
      m_done = 1'b0;
      wait_cnt = w;
    end else if (hit) begin
      m_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    dmem.dhit = 1'b0;
    en = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_dmemREN", dmem.dmemREN, 0);
    check("rst_dmemWEN", dmem.dmemWEN, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_fwd_val", fwd_val, 0);
    check("rst_wb_regwr", wb_regwr, 0);
    check("rst_wb_wdat", wb_wdat, 0);
    check("rst_wb_halt", wb_halt, 0);
    m_slot = '0;
    m_done = 1'b0;
    m_halt = 1'b0;
    m_ld = '0;
    wait_cnt = 0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    ins_t nop, ld, st, a0, a2, a3;
    dmem.dhit = 1'b0;
    dmem.dload = '0;
    nop = '0;
    do_reset();

    ld = mk(32'h100, 32'h0, 1, 0, 1, 2'd1, 5'd5, 0);
    cyc(ld, 1, 0, 2);
    for (int i = 0; i < 4; i++) cyc(nop, 1, 0, 0);

    st = mk(32'h40, 32'h1234, 0, 1, 0, 2'd0, 5'd0, 0);
    cyc(st, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(nop, 1, 0, 0);

    a0 = mk(32'd7, 32'h0, 0, 0, 1, 2'd0, 5'd1, 0);
    a2 = mk(32'h9, 32'h0, 0, 0, 1, 2'd2, 5'd2, 0);
    a3 = mk(32'h9, 32'h0, 0, 0, 1, 2'd3, 5'd3, 0);
    cyc(a0, 1, 0, 0);
    cyc(a2, 1, 0, 0);
    cyc(a3, 1, 0, 0);
    cyc(nop, 1, 0, 0);
    cyc(nop, 1, 0, 0);

    cyc(a0, 1, 0, 0);
    cyc(a2, 1, 1, 0);
    cyc(nop, 1, 0, 0);

    cyc(ld, 1, 0, 2);
    cyc(a0, 1, 1, 0);
    cyc(a0, 1, 1, 0);
    cyc(nop, 1, 0, 0);
    cyc(nop, 1, 0, 0);

    cyc(mk(32'h1, 32'h0, 0, 0, 0, 2'd0, 5'd0, 1), 1, 0, 0);
    cyc(a0, 1, 0, 0);
    cyc(a2, 1, 0, 0);
    cyc(nop, 1, 0, 0);

    cyc(ld, 1, 0, 3);
    cyc(nop, 1, 0, 0);
    do_reset();
    cyc(ld, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(nop, 1, 0, 0);

    for (int i = 0; i < 400; i++)
      cyc(rnd_ins(), $urandom_range(0, 9) != 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller.
- Sits directly downstream of the execute stage. Consumes the ALU result, store data, memory-control and writeback-control fields it produces.
- Drives the data-memory request/hit handshake and stalls the pipeline while an access is outstanding.
- Presents registered writeback fields (MEM/WB) to the register file.

Parameters:
- WORD_W, 32, datapath width.
- REG_W, 5, register-index width.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- en  input  1  advance enable from hazard unit; EX/MEM captures when en & ~mem_stall
- flush  input  1  load bubble into EX/MEM (priority over en)
- aluout  input  WORD_W  EX ALU result; also the memory address
- dmemstore_in  input  WORD_W  EX store data
- npc  input  WORD_W  PC+4 for link writes
- luiv  input  WORD_W  upper-immediate value, already shifted
- dren, dwen  input  1 each  memory read/write request from EX
- regwr  input  1  register write enable
- regsel  input  2  writeback source: 0 ALU, 1 load, 2 npc, 3 lui
- regdst  input  REG_W  destination register
- halt  input  1  halt marker
- dhit  input  1  memory access complete this cycle
- dload  input  WORD_W  load data, valid when dhit
- dmemREN, dmemWEN  output  1 each  memory request strobes
- dmemaddr  output  WORD_W  memory address
- dmemstore  output  WORD_W  store data
- mem_stall  output  1  holds all upstream stages
- fwd_regwr, fwd_regdst, fwd_val  output  1/REG_W/WORD_W  EX/MEM forwarding source; fwd_val = non-load selected value
- wb_regwr, wb_regdst, wb_wdat  output  1/REG_W/WORD_W  MEM/WB writeback
- wb_halt  output  1  sticky halt

Behaviour:
- Reset (async, nRST=0): all EX/MEM and MEM/WB registers 0, FSM IDLE, wb_halt 0. All outputs therefore 0.
- EX/MEM capture at posedge:
  - flush loads a bubble (all fields 0). A flush while mem_stall=1 is ignored.
  - Otherwise, en & ~mem_stall captures the inputs.
  - Otherwise the register holds.
- FSM, states IDLE and ACCESS:
  - IDLE: if latched dren|dwen, go to ACCESS next cycle; dmemREN/dmemWEN assert combinationally from the latched fields in the same cycle the instruction is latched.
  - ACCESS: dmemREN/dmemWEN held stable until dhit. On dhit, return to IDLE.
  - dhit in the first request cycle completes a zero-wait access, so the FSM stays in IDLE.
- Request outputs:
  - dmemREN = latched dren & ~done; dmemWEN = latched dwen & ~done. done is set on dhit and cleared on the next EX/MEM capture, so a held instruction does not re-request.
  - dmemaddr = latched aluout; dmemstore = latched store data. Both stable while the request is pending.
- mem_stall = (dmemREN|dmemWEN) & ~dhit. Combinational, so it drops in the dhit cycle.
- MEM/WB register:
  - Updates every cycle that mem_stall=0, from the EX/MEM fields.
  - wb_wdat selected by regsel; for regsel=1 it is dload sampled in the dhit cycle.
  - When mem_stall=1, MEM/WB loads a bubble (wb_regwr=0) so nothing is written twice.
- wb_halt: set when latched halt passes with mem_stall=0; remains 1 until reset.
- Both dren and dwen latched: a write-read protocol error. dwen wins, dren is ignored, and wb_wdat is the ALU value.
- Reset mid-access: request strobes drop immediately, FSM returns to IDLE.

Test Plan:
- Load, 2-wait memory: aluout=0x100, dren=1, regsel=1, regdst=5; dhit on the 3rd cycle with dload=0xDEADBEEF.
  -> dmemREN=1 and mem_stall=1 for 2 cycles, addr 0x100 stable; next cycle wb_regwr=1, wb_regdst=5, wb_wdat=0xDEADBEEF; exactly one write.
- Store, zero-wait: dwen=1, aluout=0x40, dmemstore_in=0x1234, dhit=1 immediately.
  -> dmemWEN one cycle, no stall, wb_regwr=0.
- ALU op back-to-back with regsel 0/2/3 (values 7, 0x404, 0xABCD0000).
  -> wb_wdat matches each in consecutive cycles; fwd_val correct one cycle earlier.
- Flush asserted with no access pending -> next cycle all wb outputs 0. Flush during a stalled load -> ignored, load completes.
- Halt instruction, then further instructions -> wb_halt=1 and stays 1.
- nRST pulsed during ACCESS -> dmemREN=0 at once, all outputs 0, a new load after reset behaves normally.
